nibble_serial_adder_ctrl: RTL and testbench
===========================================

// Module: nibble_serial_adder_ctrl
// PURPOSE
//  Sequencer in front of the 4-bit carry-lookahead adder slice. Accepts WIDTH-bit
//  operands over a valid/ready handshake and feeds them to the slice one nibble per
//  cycle, LSB nibble first. It chains the slice carry between nibbles, assembles the
//  slice sums into the WIDTH-bit result and presents it on a valid/ready output.
// PARAMETERS
//  WIDTH  16  operand/result width; must be a multiple of 4 and >= 8
//  NIB    WIDTH/4 (localparam)  nibble count = RUN cycles per operation
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      reset, asynchronous, active-high
//  in_valid   in   1      operands valid
//  in_ready   out  1      block can accept operands
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_cin     in   1      carry in
//  cla_a      out  4      nibble of A to slice
//  cla_b      out  4      nibble of B to slice
//  cla_cin    out  1      carry to slice
//  cla_sum    in   4      slice sum (combinational return)
//  cla_cout   in   1      slice carry out (combinational return)
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out_sum    out  WIDTH  result
//  out_cout   out  1      final carry out
//  out_ovf    out  1      signed overflow (only with SERADD_OVF_EN)
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, idx=0, a/b/sum regs=0, carry=0; in_ready=1 after
//   release; out_valid=0, out_sum=0, out_cout=0, out_ovf=0; cla_* = 0.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid&in_ready, capture in_a/in_b into a_reg/b_reg and
//   in_cin into carry_reg; idx<=0; go to RUN.
//  RUN: in_ready=0. cla_a=a_reg[4*idx+:4], cla_b=b_reg[4*idx+:4], cla_cin=carry_reg
//   (combinational from regs). Each cycle: sum_reg[4*idx+:4]<=cla_sum,
//   carry_reg<=cla_cout, idx<=idx+1. When idx==NIB-1, go to DONE.
//  DONE: out_valid=1; out_sum=sum_reg, out_cout=carry_reg, all held stable until
//   out_ready=1. On out_valid&out_ready, go to IDLE. out_valid drops the next cycle.
//  Latency: accept edge -> out_valid high exactly NIB+1 edges later (5 for WIDTH=16).
//   With out_ready tied high, throughput is 1 op per NIB+2 cycles.
//  cla_a/cla_b/cla_cin = 0 outside RUN.
//  in_valid during RUN/DONE: ignored. Operands must be re-presented; no buffering.
//  in_a/in_b/in_cin may change after acceptance; the captured copies are used.
//  out_ready while not out_valid: ignored.
//  Reset mid-RUN or mid-DONE: operation aborted, no out_valid, all state as above.
//  Widths: idx is clog2(NIB) bits and never wraps past NIB-1. Carries are
//   unsigned (modulo 2^WIDTH sum with out_cout as bit WIDTH).
// CONFIGURATION
//  SERADD_OVF_EN defined: in the last RUN cycle register
//   ovf <= carry_reg_into_top_nibble_msb XOR cla_cout, i.e.
//   (a_msb==b_msb)&&(sum_msb!=a_msb) on the captured operands. out_ovf=ovf, valid
//   with out_valid and held through DONE. ovf is cleared on capture and on reset.
//  SERADD_OVF_EN undefined: out_ovf port is present and tied to 0, with no flop.
// TESTING (WIDTH=16, slice = 4-bit CLA model, out_ready=1 unless stated)
//  1 a=0x1234 b=0x4321 cin=0 -> out_sum=0x5555 cout=0; out_valid 5 edges after accept
//  2 a=0xFFFF b=0x0001 cin=0 -> out_sum=0x0000 cout=1; cla_cin=1 in RUN cycles 1..3
//  3 a=0x0000 b=0xFFFF cin=1 -> out_sum=0x0000 cout=1 (carry ripples via cin)
//  4 out_ready low 3 cycles in DONE -> out_valid, out_sum and cout held stable;
//    in_ready=0 throughout; IDLE one cycle after out_ready high
//  5 rst pulse in RUN cycle 2, then a=0x0001 b=0x0001 -> no stale out_valid;
//    next out_sum=0x0002
//  6 SERADD_OVF_EN: 0x7FFF+0x0001 -> sum 0x8000 ovf=1; 0xFFFF+0x0001 -> ovf=0 cout=1

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// Serial adder sequencer: streams WIDTH-bit operands through an external 4-bit adder
// slice, LSB nibble first. The signed-overflow flag is built only with SERADD_OVF_EN.
module nibble_serial_adder_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [3:0]       cla_a,
  output logic [3:0]       cla_b,
  output logic             cla_cin,
  input  logic [3:0]       cla_sum,
  input  logic             cla_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned IdxW = $clog2(NIB);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIB - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             run;

  assign run = (state_q == StRun);

  always_comb begin
    cla_a   = 4'h0;
    cla_b   = 4'h0;
    cla_cin = 1'b0;
    if (run) begin
      cla_a   = a_q[{idx_q, 2'b00} +: 4];
      cla_b   = b_q[{idx_q, 2'b00} +: 4];
      cla_cin = carry_q;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[{idx_q, 2'b00} +: 4] = cla_sum;
        carry_d = cla_cout;
        // idx parks on the last nibble rather than wrapping
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

`ifdef SERADD_OVF_EN
  logic ovf_q, ovf_d;

  // Signed overflow = carry into the top bit XOR carry out of it, recovered from the slice.
  always_comb begin
    ovf_d = ovf_q;
    if ((state_q == StIdle) && in_valid) begin
      ovf_d = 1'b0;
    end else if (run && (idx_q == LastIdx)) begin
      ovf_d = (cla_a[3] ^ cla_b[3] ^ cla_sum[3]) ^ cla_cout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign out_ovf = (state_q == StDone) ? ovf_q : 1'b0;
`else
  assign out_ovf = 1'b0;
`endif

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_sum   = out_valid ? sum_q : '0;
  assign out_cout  = out_valid ? carry_q : 1'b0;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl (WIDTH=16) with a behavioural
// 4-bit adder slice and an arithmetic reference model.
module tb_nibble_serial_adder_ctrl;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic [3:0]   cla_a, cla_b, cla_sum;
  logic         cla_cin, cla_cout;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_cout, out_ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign {cla_cout, cla_sum} = {1'b0, cla_a} + {1'b0, cla_b} + {4'b0000, cla_cin};

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .cla_a    (cla_a),
    .cla_b    (cla_b),
    .cla_cin  (cla_cin),
    .cla_sum  (cla_sum),
    .cla_cout (cla_cout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf)
  );

  // Reference: 17-bit sum and signed overflow of the operands.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, b, input logic cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, b, input logic cin);
    logic [W:0] s;
    s = ref_sum(a, b, cin);
`ifdef SERADD_OVF_EN
    return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
`else
    return 1'b0;
`endif
  endfunction

  // Drives one operation; latency counts edges inclusive of the accepting edge.
  task automatic run_op(input logic [W-1:0] a, b, input logic cin, input logic rdy,
                        output logic [W-1:0] s, output logic co, ov, output int lat);
    int n;
    @(negedge clk);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1; out_ready = rdy;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) lat = 0;
    s = out_sum; co = out_cout; ov = out_ovf;
    if (rdy) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_sum !== 16'h0) begin bad++; $display("FAIL reset_out_sum got=%h exp=0000", out_sum); end
    total++; if (out_cout !== 1'b0) begin bad++; $display("FAIL reset_out_cout got=%b exp=0", out_cout); end
    total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL reset_out_ovf got=%b exp=0", out_ovf); end
    total++; if ({cla_a, cla_b, cla_cin} !== 9'h0) begin bad++; $display("FAIL reset_cla got=%h exp=0", {cla_a, cla_b, cla_cin}); end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [3];
    logic [W-1:0] vb [3];
    logic         vc [3];
    logic [W-1:0] s;
    logic [W:0]   e;
    logic         co, ov;
    int           lat;
    va = '{16'h1234, 16'hFFFF, 16'h0000};
    vb = '{16'h4321, 16'h0001, 16'hFFFF};
    vc = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], vc[i], 1'b1, s, co, ov, lat);
      e = ref_sum(va[i], vb[i], vc[i]);
      total++; if (s !== e[W-1:0]) begin bad++; $display("FAIL dir%0d_sum got=%h exp=%h", i, s, e[W-1:0]); end
      total++; if (co !== e[W]) begin bad++; $display("FAIL dir%0d_cout got=%b exp=%b", i, co, e[W]); end
      total++; if (lat != 5) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=5", i, lat); end
    end
  endtask

  task automatic test_cla_cin();
    logic [W-1:0] a, b;
    int unsigned  mask, c;
    a = 16'hFFFF; b = 16'h0001;
    @(negedge clk);
    in_a = a; in_b = b; in_cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mask = (i == 0) ? 0 : ((32'd1 << (4 * i)) - 1);
      c = ((int'(a) & mask) + (int'(b) & mask)) >> (4 * i);
      total++; if (cla_cin !== c[0]) begin bad++; $display("FAIL cla_cin_nib%0d got=%b exp=%b", i, cla_cin, c[0]); end
      total++; if (cla_a !== a[4*i +: 4]) begin bad++; $display("FAIL cla_a_nib%0d got=%h exp=%h", i, cla_a, a[4*i +: 4]); end
      @(posedge clk);
      #1;
    end
    total++; if ({out_valid, cla_cin, cla_a} !== 6'b100000) begin bad++; $display("FAIL cla_idle_done got=%b exp=100000", {out_valid, cla_cin, cla_a}); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] s;
    logic         co, ov;
    int           lat;
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, co, ov, lat);
    total++; if (lat != 5) begin bad++; $display("FAIL bp_latency got=%0d exp=5", lat); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++; if ({out_valid, in_ready, out_cout} !== 3'b101) begin bad++; $display("FAIL bp_hold%0d_flags got=%b exp=101", i, {out_valid, in_ready, out_cout}); end
      total++; if (out_sum !== 16'h0000) begin bad++; $display("FAIL bp_hold%0d_sum got=%h exp=0000", i, out_sum); end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL bp_release got=%b exp=10", {in_ready, out_valid}); end
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] s;
    logic         co, ov;
    int           lat, seen;
    @(negedge clk);
    in_a = 16'hABCD; in_b = 16'h1111; in_cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++; if ({out_valid, cla_a, cla_b, cla_cin} !== 10'h0) begin bad++; $display("FAIL abort_outputs got=%h exp=0", {out_valid, cla_a, cla_b, cla_cin}); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL abort_stale_valid got=%0d exp=0", seen); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
    run_op(16'h0001, 16'h0001, 1'b0, 1'b1, s, co, ov, lat);
    total++; if ({co, s} !== 17'h00002) begin bad++; $display("FAIL abort_next_sum got=%h exp=00002", {co, s}); end
  endtask

  task automatic test_ovf();
    logic [W-1:0] s;
    logic         co, ov;
    int           lat;
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, s, co, ov, lat);
    total++; if ({co, s} !== 17'h08000) begin bad++; $display("FAIL ovf_pos_sum got=%h exp=08000", {co, s}); end
    total++; if (ov !== ref_ovf(16'h7FFF, 16'h0001, 1'b0)) begin bad++; $display("FAIL ovf_pos_flag got=%b exp=%b", ov, ref_ovf(16'h7FFF, 16'h0001, 1'b0)); end
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b1, s, co, ov, lat);
    total++; if ({co, ov} !== 2'b10) begin bad++; $display("FAIL ovf_wrap got=%b exp=10", {co, ov}); end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, s;
    logic         cin, co, ov;
    logic [W:0]   e;
    int           lat;
    for (int i = 0; i < 20; i++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      if (i == 0) begin a = 16'h8000; b = 16'h8000; end
      run_op(a, b, cin, 1'b1, s, co, ov, lat);
      e = ref_sum(a, b, cin);
      total++; if ({co, s} !== e) begin bad++; $display("FAIL rand%0d_sum a=%h b=%h cin=%b got=%h exp=%h", i, a, b, cin, {co, s}, e); end
      total++; if (ov !== ref_ovf(a, b, cin)) begin bad++; $display("FAIL rand%0d_ovf got=%b exp=%b", i, ov, ref_ovf(a, b, cin)); end
      total++; if (lat != 5) begin bad++; $display("FAIL rand%0d_latency got=%0d exp=5", i, lat); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W:0] expq [$];
    int         acc [$];
    logic [W:0] e;
    logic       renew;
    renew = 1'b0;
    @(negedge clk);
    in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (renew) begin
        in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
        renew = 1'b0;
      end
      if (out_valid) begin
        e = (expq.size() > 0) ? expq.pop_front() : '0;
        total++; if ({out_cout, out_sum} !== e) begin bad++; $display("FAIL b2b_sum cyc=%0d got=%h exp=%h", cyc, {out_cout, out_sum}, e); end
      end
      if (in_ready) begin
        expq.push_back(ref_sum(in_a, in_b, in_cin));
        acc.push_back(cyc);
        renew = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++; if (acc.size() != 4) begin bad++; $display("FAIL b2b_accepts got=%0d exp=4", acc.size()); end
    for (int i = 1; i < acc.size(); i++) begin
      total++; if (acc[i] - acc[i-1] != 6) begin bad++; $display("FAIL b2b_period%0d got=%0d exp=6", i, acc[i] - acc[i-1]); end
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_cla_cin();
    test_backpressure();
    test_reset_abort();
    test_ovf();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
